pll_lock_ctrl: RTL
==================

Name: pll_lock_ctrl

Overview:
Reset/lock sequencer for a single general-purpose PLL instance (e.g. the 219.140625 MHz refclk-to-outclk PLL). It runs on the PLL's free-running reference clock and holds the PLL reset for a minimum time, then waits for lock. It qualifies lock over a stability window, then releases a ready flag to downstream logic. It also detects loss of lock and retries on timeout, giving up with a sticky fault after a bounded number of attempts.

Parameters:
RST_HOLD_CYC, 64, cycles the pll_rst output is held high per attempt (min 2)
LOCK_TIMEOUT_CYC, 65536, cycles allowed in WAIT_LOCK before a retry
STABLE_CYC, 1024, consecutive synchronized-locked cycles required before ready
MAX_RETRY, 7, timeouts tolerated before FAULT (1..15)
CNT_W, 17, width of the shared timer; must hold max(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC)

Ports:
refclk  in  1  free-running reference clock, sole clock of block
rst  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL locked output, asynchronous to refclk
restart  in  1  single-cycle request to re-run the full sequence
pll_rst  out  1  reset to PLL rst pin
clk_ready  out  1  PLL output qualified stable
fault  out  1  sticky: retries exhausted
retry_cnt  out  4  timeouts in current sequence
lol_cnt  out  8  loss-of-lock events since reset, saturating at 255
state  out  3  current FSM state encoding, for debug CSR

Behaviour:
- Clock and reset: one clock, refclk. Reset is asynchronous and active-high on rst; all flops clear on rst.
- Values while rst is high: pll_rst=1, clk_ready=0, fault=0, retry_cnt=0, lol_cnt=0, state=RST_HOLD, timer=0, synchronizer=0.
- Lock synchronizer: pll_locked passes through a 2-flop synchronizer to give lk_s. The FSM uses only lk_s, so any lock edge reaches the FSM 2 cycles late.
- Timer: a single CNT_W-bit timer, cleared on every state entry and incremented each cycle in the timed states.
- States and encodings:
  - RST_HOLD (0): pll_rst=1. When timer==RST_HOLD_CYC-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_HOLD_CYC cycles.
  - WAIT_LOCK (1): pll_rst=0.
    - If lk_s=1, go to STABLE.
    - Else if timer==LOCK_TIMEOUT_CYC-1, increment retry_cnt. If the new value is greater than MAX_RETRY, go to FAULT; otherwise go to RST_HOLD.
  - STABLE (2):
    - lk_s=0: go back to WAIT_LOCK. This is a glitch during qualification: it is not counted in lol_cnt and the timer restarts.
    - timer==STABLE_CYC-1 with lk_s=1: go to LOCKED.
  - LOCKED (3): clk_ready=1 (registered, asserted the first cycle in LOCKED). On lk_s=0, increment lol_cnt (saturating), clear retry_cnt and go to RST_HOLD. clk_ready drops on the same edge the state leaves.
  - FAULT (4): pll_rst=1, fault=1, clk_ready=0. The only exits are restart or rst.
- restart:
  - In any state, restart=1 forces RST_HOLD on the next edge, clears retry_cnt and fault, and keeps lol_cnt.
  - restart has priority over every other transition in the same cycle.
  - If restart is held for multiple cycles, RST_HOLD re-enters and the timer re-clears each cycle.
- Registered outputs: all outputs come from flops, with no combinational path from inputs.
- Unused encodings 5–7 recover to RST_HOLD.

Decomposition:
- Shared package pll_ctrl_pkg:
  - state enum (RST_HOLD, WAIT_LOCK, STABLE, LOCKED, FAULT) with fixed 3-bit encodings, exported to the CSR map.
  - LOL_CNT_W=8.
  - RETRY_W=4.
- Sub-module: sync_2ff, a generic 2-flop bit synchronizer with async reset. The team reuses it elsewhere.
- The FSM, timer and counters stay in pll_lock_ctrl.

Test Plan:
Bench parameters for all scenarios: RST_HOLD_CYC=4, LOCK_TIMEOUT_CYC=32, STABLE_CYC=8, MAX_RETRY=2.
1. Nominal lock: release rst, then raise pll_locked 10 cycles after pll_rst falls. Required: pll_rst high exactly 4 cycles; clk_ready rises 2+8 cycles after the pll_locked edge; state=3.
2. Timeout and fault: hold pll_locked=0. Required: three reset pulses of 4 cycles, each followed by a 32-cycle wait; retry_cnt steps 1,2,3; fault=1 and state=4 after the third timeout; pll_rst stays 1.
3. Qualification glitch: pll_locked high for 5 cycles, low for 1, then high. Required: return to WAIT_LOCK; lol_cnt stays 0; clk_ready asserts 8 cycles after the second synchronized edge.
4. Loss of lock: from LOCKED, drop pll_locked. Required: after 2 synchronizer cycles, clk_ready=0, pll_rst=1, lol_cnt=1, retry_cnt=0. Repeating 300 times gives lol_cnt=255 (saturated).
5. Restart and reset priority:
   - Pulse restart in FAULT: fault clears next edge, then a normal sequence follows.
   - Pulse restart in the same cycle as the STABLE→LOCKED condition: state=RST_HOLD.
   - Assert rst mid-WAIT_LOCK: all outputs take their reset values immediately (asynchronously).

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encodings and counter widths for the PLL lock sequencer
// State encodings are fixed because they are exported to the debug CSR map.
package pll_ctrl_pkg;
  localparam int LOL_CNT_W = 8;
  localparam int RETRY_W = 4;
  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    LOCKED    = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 2-flop bit synchronizer with asynchronous active-high reset
// Ports: i_clk destination clock, i_rst async reset, i_d async input, o_q synchronized output
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sh;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_sh <= '0;
    else r_sh <= {r_sh[0], i_d};
  assign o_q = r_sh[1];
endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset/lock sequencer with lock qualification, loss-of-lock tracking and bounded retries
// Ports: i_refclk free-running clock, i_rst async reset, i_pll_locked async lock flag,
//        i_restart re-run request, o_pll_rst PLL reset, o_clk_ready qualified lock,
//        o_fault sticky retry exhaustion, o_retry_cnt timeouts, o_lol_cnt loss-of-lock events,
//        o_state debug state encoding
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYC     = 64,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STABLE_CYC       = 1024,
  parameter int MAX_RETRY        = 7,
  parameter int CNT_W            = 17
) (
  input  logic                 i_refclk,
  input  logic                 i_rst,
  input  logic                 i_pll_locked,
  input  logic                 i_restart,
  output logic                 o_pll_rst,
  output logic                 o_clk_ready,
  output logic                 o_fault,
  output logic [RETRY_W-1:0]   o_retry_cnt,
  output logic [LOL_CNT_W-1:0] o_lol_cnt,
  output logic [2:0]           o_state
);
  localparam logic [CNT_W-1:0] L_HOLD_END = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_TO_END   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] L_STAB_END = CNT_W'(STABLE_CYC - 1);
  localparam logic [RETRY_W:0] L_MAX      = (RETRY_W + 1)'(MAX_RETRY);
  pll_state_t r_state, w_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [RETRY_W-1:0] r_retry;
  logic [LOL_CNT_W-1:0] r_lol;
  logic r_pll_rst, r_clk_ready, r_fault;
  logic w_lk_s, w_timeout, w_lol, w_enter, w_timed;
  logic [RETRY_W:0] w_retry_inc;
  sync_2ff u_sync (
    .i_clk(i_refclk),
    .i_rst(i_rst),
    .i_d  (i_pll_locked),
    .o_q  (w_lk_s)
  );
  always_comb begin
    w_retry_inc = {1'b0, r_retry} + (RETRY_W + 1)'(1);
    w_timeout   = r_state == WAIT_LOCK && !w_lk_s && r_timer == L_TO_END;
    w_lol       = r_state == LOCKED && !w_lk_s && !i_restart;
    w_timed     = r_state == RST_HOLD || r_state == WAIT_LOCK || r_state == STABLE;
    w_nxt = i_restart ? RST_HOLD :
            r_state == RST_HOLD  ? (r_timer == L_HOLD_END ? WAIT_LOCK : RST_HOLD) :
            r_state == WAIT_LOCK ? (w_lk_s ? STABLE :
                                    w_timeout ? (w_retry_inc > L_MAX ? FAULT : RST_HOLD) : WAIT_LOCK) :
            r_state == STABLE    ? (!w_lk_s ? WAIT_LOCK : r_timer == L_STAB_END ? LOCKED : STABLE) :
            r_state == LOCKED    ? (w_lk_s ? LOCKED : RST_HOLD) :
            r_state == FAULT     ? FAULT : RST_HOLD;
    // restart while already in RST_HOLD still counts as a fresh entry
    w_enter = i_restart || w_nxt != r_state;
  end
  always_ff @(posedge i_refclk or posedge i_rst)
    if (i_rst) begin
      r_state     <= RST_HOLD;
      r_timer     <= '0;
      r_retry     <= '0;
      r_lol       <= '0;
      r_pll_rst   <= 1'b1;
      r_clk_ready <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_timer     <= w_enter ? '0 : w_timed ? r_timer + CNT_W'(1) : r_timer;
      r_retry     <= (i_restart || w_lol) ? '0 :
                     w_timeout ? (w_retry_inc[RETRY_W] ? '1 : w_retry_inc[RETRY_W-1:0]) : r_retry;
      r_lol       <= (w_lol && !(&r_lol)) ? r_lol + LOL_CNT_W'(1) : r_lol;
      // outputs follow the state being entered so they change on the same edge as the state
      r_pll_rst   <= w_nxt == RST_HOLD || w_nxt == FAULT;
      r_clk_ready <= w_nxt == LOCKED;
      r_fault     <= w_nxt == FAULT;
    end
  assign o_pll_rst   = r_pll_rst;
  assign o_clk_ready = r_clk_ready;
  assign o_fault     = r_fault;
  assign o_retry_cnt = r_retry;
  assign o_lol_cnt   = r_lol;
  assign o_state     = r_state;
endmodule
